// File: rtl/pm_pkg.sv
// Shared types and helpers for the pm mux select generator.
package pm_pkg;

  localparam int PM_MAX_N = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } pm_sel_state_t;

  // Select width for an n-input mux; a single input still needs one select bit.
  function automatic int pm_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pm_rr_pick.sv
// Rotate-priority picker: first set bit of vec searching start, start+1, ... modulo N.
module pm_rr_pick
  import pm_pkg::*;
#(
  parameter int N = 4,
  localparam int SW = pm_sel_w(N)
) (
  input  logic [N-1:0]  vec,
  input  logic [SW-1:0] start,
  output logic [SW-1:0] idx,
  output logic          any
);

  int k;

  // Walk the search order backwards so the earliest candidate is written last and wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(start) + i) % N;
      if (vec[k]) begin
        idx = SW'(k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pm_rr_sel.sv
// Round-robin select generator for the pm N:1 mux with valid/ready handshake.
// Optional burst mode is compiled in when PM_SEL_BURST_EN is defined.
module pm_rr_sel
  import pm_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = 4,
  localparam int SW = pm_sel_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          ready,
  output logic [SW-1:0] s,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  pm_sel_state_t state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic [N-1:0]  s_onehot;
  logic [SW-1:0] s_inc;
  logic          req_s;
  logic [N-1:0]  pick_vec;
  logic [SW-1:0] pick_start;
  logic [SW-1:0] pick_idx;
  logic          pick_any;
  logic          rotate;

`ifdef PM_SEL_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  assign s_onehot = N'(1) << s_q;
  assign s_inc    = (s_q == LAST) ? '0 : s_q + 1'b1;
  assign req_s    = req[s_q];

  // One picker serves both cases: raw requests from ptr in IDLE, or the
  // post-grant view with the current winner masked, searched from s+1.
  always_comb begin
    pick_vec   = req;
    pick_start = ptr_q;
    if (state_q == GRANT) begin
      pick_vec   = req & ~s_onehot;
      pick_start = s_inc;
    end
  end

  pm_rr_pick #(.N(N)) u_pick (
    .vec   (pick_vec),
    .start (pick_start),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    ptr_d   = ptr_q;
    rotate  = 1'b0;
`ifdef PM_SEL_BURST_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef PM_SEL_BURST_EN
        cnt_d = '0;
`endif
        if (pick_any) begin
          state_d = GRANT;
          s_d     = pick_idx;
        end
      end
      GRANT: begin
        if (ready) begin
`ifdef PM_SEL_BURST_EN
          if (req_s && (int'(cnt_q) < MAX_BURST - 1)) cnt_d = cnt_q + 1'b1;
          else                                        rotate = 1'b1;
`else
          rotate = 1'b1;
`endif
        end else if (!req_s) begin
          rotate = 1'b1;
        end
        if (rotate) begin
          ptr_d = s_inc;
`ifdef PM_SEL_BURST_EN
          cnt_d = '0;
`endif
          if (pick_any) s_d = pick_idx;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      ptr_q   <= '0;
`ifdef PM_SEL_BURST_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
`ifdef PM_SEL_BURST_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    valid = (state_q == GRANT);
    s     = s_q;
    gnt   = valid ? s_onehot : '0;
  end

endmodule

// File: doc/pm_rr_sel.md
# pm_rr_sel

Round-robin select generator that sits directly upstream of the parameterized N:1 mux `pm`. It arbitrates among N request lines and drives the mux select `s` with a registered, glitch-free index. It also provides a valid/ready handshake so the consumer of `y` knows when the selected input is stable and has been taken. Grants rotate fairly, so no input is starved.

## Interface
- `N`, default 4: number of mux inputs/requesters; legal range 1..64.
- `MAX_BURST`, default 4: maximum consecutive transfers per grant. Only used when `PM_SEL_BURST_EN` is defined; legal range ≥1.
- `SW` (derived, not overridable): N>1 ? $clog2(N) : 1.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req`  in  N  per-input request; bit k set means input k has data for the mux.
- `ready`  in  1  downstream has taken `y` this cycle.
- `s`  out  SW  mux select, connects to `pm.s`.
- `gnt`  out  N  one-hot grant, equal to 1<<s while `valid`, else 0.
- `valid`  out  1  `s` is granted and the mux output is meaningful.

## Operation
- Two-state FSM:
  - IDLE: `valid`=0.
  - GRANT: `valid`=1.
- Priority pointer `ptr` (SW bits) holds the index searched first. Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N, not modulo 2^SW).
- IDLE:
  - If `req`≠0, load `s` with the first set bit in search order and go to GRANT.
  - Otherwise stay in IDLE; `s` holds its value.
- GRANT, no transfer (`ready`=0):
  - `s` and `gnt` are held.
  - If `req[s]` drops, the grant is revoked without a transfer, and the next state is computed as for a transfer (below) without advancing the burst count.
- GRANT, transfer (`ready`=1):
  - `ptr` ← (s+1) mod N.
  - Choose the next winner from `req` with `req[s]` masked, in the new search order.
  - If there is a winner: `s` ← winner and stay in GRANT. This gives back-to-back grants with no bubble.
  - If there is no winner: go to IDLE.
- Requests arriving mid-grant are queued implicitly in `req`. There is no storage inside the block.
- N=1: `s` is constantly 0 and `ptr` is constantly 0. The FSM still runs the valid/ready handshake.

## Timing
- Reset values: `s`=0, `ptr`=0, `valid`=0, `gnt`=0, state IDLE, burst count 0.
- Latency: `req` rising in IDLE gives `valid`=1 on the next rising edge (1 cycle).
- A transfer at edge t with another request pending gives the new `s` and `valid`=1 at edge t, so there is no dead cycle.
- `s` changes only on an edge where `valid`=0 or a transfer/revoke occurs. It never changes while valid&&!ready with `req[s]` held.
- `ready` is ignored while `valid`=0.
- Reset asserted mid-grant immediately forces the reset values. No transfer is reported.

## Configuration
- `PM_SEL_BURST_EN` defined: a burst counter (width $clog2(MAX_BURST+1)) is compiled in.
  - On a transfer with `req[s]` still high and count < MAX_BURST-1: keep `s`, increment the count, leave `ptr` unchanged.
  - Otherwise rotate as above and clear the count.
  - The count also clears on revoke and in IDLE.
- `PM_SEL_BURST_EN` undefined: no counter logic. Every transfer rotates, which is equivalent to MAX_BURST=1.

## Structure
- Package `pm_pkg`:
  - `pm_sel_state_t` enum {IDLE, GRANT}.
  - Function `pm_sel_w(n)` returning SW.
  - Constant `PM_MAX_N`=64.
- Sub-module `pm_rr_pick`: purely combinational rotate-priority picker.
  - Inputs: `vec[N]`, `start[SW]`.
  - Outputs: `idx[SW]`, `any`.
  - Instantiated once. It is reused for the IDLE pick and the post-transfer pick through a muxed masked vector.

## Test plan
All scenarios use N=4.
- Reset/idle: hold `rst_n`=0, then release with `req`=0 → `s`=0, `valid`=0, `gnt`=0 for 10 cycles.
- Single request: `req`=4'b0100 from IDLE → next edge `s`=2, `gnt`=4'b0100, `valid`=1; holds with `ready`=0; one `ready` pulse gives IDLE next cycle.
- Fair rotation: `req`=4'b1111, `ready`=1 constant → `s` sequence 0,1,2,3,0,… with no valid gaps. With `PM_SEL_BURST_EN` and MAX_BURST=2 → 0,0,1,1,2,2,3,3.
- Wrap/skip: `req`=4'b1001, `ptr` after grant of 3 → next `s`=0, then 3, then 0.
- Stall and revoke: grant s=1 with `ready`=0 for 5 cycles → `s` is stable. Drop `req[1]` with `req`=4'b0100 → next edge `s`=2, no transfer counted.
- Async reset mid-grant: assert `rst_n`=0 between edges while `valid`=1 → `valid`, `gnt`, `s` go to 0 immediately, without waiting for a clock edge.
